// File: rtl/img_loader_pkg.sv
// Shared image-path definitions: loader FSM state encoding and the default
// frame delimiter bytes, reused by the VGA reader side.
package img_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIXELS,
        ST_TAIL,
        ST_DONE,
        ST_ERR
    } img_state_e;

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] EOF_BYTE = 8'h5A;

endpackage

// File: rtl/img_loader_if.sv
// Loader bus: UART byte input plus frame-buffer write port and status.
//   master : the loader (consumes rx_*, drives wr_*, buf_sel, busy, pulses)
//   slave  : the surrounding system (drives rx_*, observes the rest)
interface img_loader_if #(
    parameter int AW = 12
) ();
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [7:0]    wr_data;
    logic          buf_sel;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    modport master (
        input  rx_rdy, rx_data,
        output wr_en, wr_addr, wr_data, buf_sel, busy, frame_done, frame_err
    );

    modport slave (
        output rx_rdy, rx_data,
        input  wr_en, wr_addr, wr_data, buf_sel, busy, frame_done, frame_err
    );
endinterface

// File: rtl/img_loader_idle_timer.sv
// Inter-byte idle timer.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : restart count (a byte arrived)
//   enable   : count while a frame is in progress; held at zero otherwise
//   expire   : count has reached TIMEOUT-1
module idle_timer #(
    parameter int unsigned TIMEOUT = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expire = enable && (cnt_q == LAST);
endmodule

// File: rtl/img_loader.sv
// Double-buffered frame loader: receives SOF, NPIX pixel bytes, EOF from a
// UART and writes pixels into the back buffer, flipping buffers on commit.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : img_loader_if master (rx_rdy/rx_data in; wr_en, wr_addr,
//              wr_data, buf_sel, busy, frame_done, frame_err out)
module img_loader
    import img_pkg::*;
#(
    parameter int unsigned NPIX    = 3072,
    parameter int unsigned AW      = 12,
    parameter int unsigned TIMEOUT = 120000,
    parameter logic [7:0]  SOF     = SOF_BYTE,
    parameter logic [7:0]  EOF     = EOF_BYTE
) (
    input  logic            clk,
    input  logic            rst,
    img_loader_if.master    bus
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

    img_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          wr_en_q, wr_en_d;
    logic [AW:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          buf_sel_q, buf_sel_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          tmo_expire;

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.rx_rdy),
        .enable ((state_q == ST_PIXELS) || (state_q == ST_TAIL)),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        buf_sel_d = buf_sel_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_rdy && (bus.rx_data == SOF)) begin
                    state_d = ST_PIXELS;
                    idx_d   = '0;
                end
            end
            ST_PIXELS: begin
                // rx_rdy takes priority over a simultaneous timeout
                if (bus.rx_rdy) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {~buf_sel_q, idx_q};
                    wr_data_d = bus.rx_data;
                    if (idx_q == LAST_IDX) state_d = ST_TAIL;
                    else                   idx_d   = idx_q + 1'b1;
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_TAIL: begin
                if (bus.rx_rdy) begin
                    state_d = (bus.rx_data == EOF) ? ST_DONE : ST_ERR;
                end else if (tmo_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                buf_sel_d = ~buf_sel_q;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next-state decode
        busy_d       = (state_d == ST_PIXELS) || (state_d == ST_TAIL);
        frame_done_d = (state_d == ST_DONE);
        frame_err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            buf_sel_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            buf_sel_q    <= buf_sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.buf_sel    = buf_sel_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
endmodule
